// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the 1101 sequence detector controller.
package seq_detect_pkg;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 5;

  // Marker for "no match seen yet" in the first-position field.
  localparam logic [4:0] NO_MATCH = 5'h1F;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StShift = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Detector states name the longest suffix of the input that prefixes 1101.
  typedef enum logic [1:0] {
    DetS0   = 2'd0,
    DetS1   = 2'd1,
    DetS11  = 2'd2,
    DetS110 = 2'd3
  } det_state_e;

endpackage

// File: rtl/mealy_1101.sv
// Overlapping Mealy detector for the serial pattern 1101.
module mealy_1101
  import seq_detect_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       x,
  output logic       z,
  output logic [1:0] seq
);

  det_state_e state_q, state_d;

  // Next-state and Mealy output; a match falls back to DetS1 so overlaps are counted.
  always_comb begin
    state_d = state_q;
    z       = 1'b0;
    case (state_q)
      DetS0:   state_d = x ? DetS1 : DetS0;
      DetS1:   state_d = x ? DetS11 : DetS0;
      DetS11:  state_d = x ? DetS11 : DetS110;
      DetS110: begin
        state_d = x ? DetS1 : DetS0;
        z       = x;
      end
      default: state_d = DetS0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= DetS0;
    else       state_q <= state_d;
  end

  assign seq = state_q;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Serialises a pattern word MSB-first into the 1101 detector and reports
// match count and first match position via a start/busy/done handshake.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int unsigned W  = 16,
  parameter int unsigned CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  data_in,
  input  logic [CW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] match_cnt,
  output logic [CW-1:0] first_pos,
  output logic          x_dbg
);

  localparam logic [CW-1:0] NoMatch = CW'(NO_MATCH);
  localparam logic [CW-1:0] MaxLen  = CW'(W);

  state_e        state_q, state_d;
  logic [W-1:0]  sreg_q, sreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] match_cnt_q, match_cnt_d;
  logic [CW-1:0] first_pos_q, first_pos_d;
  logic          det_clr_q, det_clr_d;
  logic [CW-1:0] len_sat;
  logic          x;
  logic          z;

  assign len_sat = (len > MaxLen) ? MaxLen : len;

  // FSM next state, datapath updates and serial bit selection.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    match_cnt_d = match_cnt_q;
    first_pos_d = first_pos_q;
    det_clr_d   = 1'b0;
    x           = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StLoad;
          // Registered so the detector is held in reset for the whole LOAD cycle.
          det_clr_d = 1'b1;
        end
      end
      StLoad: begin
        sreg_d      = data_in;
        cnt_d       = len_sat;
        idx_d       = '0;
        match_cnt_d = '0;
        first_pos_d = NoMatch;
        state_d     = (len_sat == '0) ? StDone : StShift;
      end
      StShift: begin
        x = sreg_q[W-1];
        if (z) begin
          if (match_cnt_q != '1) match_cnt_d = match_cnt_q + CW'(1);
          if (first_pos_q == NoMatch) first_pos_d = idx_q;
        end
        sreg_d = {sreg_q[W-2:0], 1'b0};
        idx_d  = idx_q + CW'(1);
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Controller state and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      sreg_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      match_cnt_q <= '0;
      first_pos_q <= NoMatch;
      det_clr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      match_cnt_q <= match_cnt_d;
      first_pos_q <= first_pos_d;
      det_clr_q   <= det_clr_d;
    end
  end

  mealy_1101 u_det (
    .clk   (clk),
    .reset (reset | det_clr_q),
    .x     (x),
    .z     (z),
    .seq   ()
  );

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign match_cnt = match_cnt_q;
  assign first_pos = first_pos_q;
  assign x_dbg     = x;

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Controller that sequences the 1101 Mealy sequence detector. It accepts a parallel word of up to 16 bits and serialises it MSB-first into the detector's x input, one bit per clock. It counts the detector's z pulses and reports the match count and the first match position through a start/busy/done handshake. It sits between a register or host interface and the existing detector datapath, which it instantiates and owns.

## Interface
Parameters:
- W, 16: maximum pattern length in bits.
- CW, 5: width of the length, count and position fields.

Ports:
- clk  in  1  system clock, all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a run; sampled only in IDLE.
- data_in  in  W  pattern word; bit W-1 is sent first.
- len  in  CW  number of bits to send, 0..16; values above 16 saturate to 16.
- busy  out  1  high from LOAD through DONE inclusive.
- done  out  1  one-cycle pulse in DONE.
- match_cnt  out  CW  number of z pulses in the last run; held until the next LOAD.
- first_pos  out  CW  bit index (0 = first bit sent) of the bit that completed the first match; 5'h1F if there was no match.
- x_dbg  out  1  bit currently driven to the detector (debug tap).

## Operation
FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE: x = 0. On start = 1, go to LOAD.
- LOAD:
  - Capture data_in into the shift register and min(len,16) into the bit counter.
  - Clear match_cnt to 0, set first_pos to 5'h1F, clear the bit index to 0.
  - Assert det_clr for this one cycle.
  - If the captured length is 0, go to DONE; otherwise go to SHIFT.
- SHIFT, once per cycle:
  - x = shift_reg[W-1].
  - If z = 1 in this cycle, increment match_cnt. If first_pos is 5'h1F, load the bit index into first_pos.
  - Shift the register left, filling with 0. Increment the bit index. Decrement the bit counter.
  - When the bit counter reaches 1 in this cycle, go to DONE.
- DONE: done = 1, then go to IDLE.

Detector handling:
- The detector reset is driven by reset OR det_clr, where det_clr is a registered signal, so the detector enters each run from its initial state.
- Matches overlap, as the detector implements them: 1101101 gives 2 matches.
- z is a Mealy output, so it is sampled in the same cycle that x is driven.

Other rules:
- start while busy is ignored; it is neither queued nor able to restart a run.
- match_cnt saturates at 2^CW-1. This cannot be reached with W = 16, but saturation is still required.

## Timing
- Reset values: FSM = IDLE, busy = 0, done = 0, match_cnt = 0, first_pos = 5'h1F, x_dbg = 0, shift register = 0, det_clr = 0.
- If start is sampled high at edge T0:
  - LOAD occupies cycle T0..T1.
  - The first bit is on x during T1..T2.
  - done is high during cycle T(len+1)..T(len+2).
  - For len = 0, done is high during T1..T2.
- Results are valid when done is high and hold stable until the next LOAD.
- Back-to-back runs: start held high during DONE is not sampled. It is accepted in the following IDLE cycle, so there is at least one IDLE cycle between runs.
- Reset asserted mid-SHIFT takes effect immediately. All outputs return to their reset values, the detector is reset, and no done pulse is issued.

## Structure
- Shared package (seq_detect_pkg): state encoding constants (IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3), NO_MATCH = 5'h1F, W, CW.
- One sub-module: mealy_1101, instantiated as the detector, with ports clk, reset (driven by reset | det_clr), x, z and seq (seq left unconnected).
- Everything else is in one module: FSM, shift register, bit counter, bit index, match counter.

## Test plan
- Basic run: data_in = 16'hDB40 (1101_1011_0100_0000), len = 16, start pulse. Required: match_cnt = 3, first_pos = 3, done exactly 17 cycles after the start edge, busy high for 18 cycles.
- No match: data_in = 16'hFFFF, len = 16. Required: match_cnt = 0, first_pos = 5'h1F, one done pulse.
- Short run and zero length:
  - data_in = 16'hD000, len = 4. Required: match_cnt = 1, first_pos = 3, done at start+5.
  - len = 0. Required: match_cnt = 0, done at start+1.
- Start while busy: pulse start again mid-SHIFT with different data_in. Required: results match the first word only, and only one done pulse.
- Reset mid-run: assert reset after 6 SHIFT cycles of 16'hDB40. Required: outputs return to reset values immediately and no done pulse. A new run of 16'hD000, len = 4, then gives match_cnt = 1, which shows the detector state was cleared.
- Back-to-back runs: run 16'h0D00 (len = 8) and then 16'hD000 (len = 4), each with its own start. Required: match_cnt = 1 each time and first_pos = 7 for the first run, with no match carried across runs.
